// File: rtl/fsm_counter_seq.sv
// fsm_counter_seq: Moore sequencer that counts a programmable range on go,
// then holds a done indication for a programmable number of ticks.
//
// Ports:
//   clk         board clock, rising edge
//   rst_btn     asynchronous active-low reset
//   go_btn      active-low go button, asynchronous to clk
//   dir         0 = count up, 1 = count down (sampled on the start tick)
//   led         current count
//   done_signal high while in DONE
//   busy        high while in COUNTING
//
// Optional feature: define FSM_COUNTER_SEQ_ABORT_EN so that a go request
// on a tick while counting aborts the run back to IDLE.
module fsm_counter_seq #(
    parameter int CLK_DIV   = 1500000,
    parameter int CNT_WIDTH = 4,
    parameter int CNT_MAX   = 15,
    parameter int DONE_HOLD = 1
) (
    input  logic                 clk,
    input  logic                 rst_btn,
    input  logic                 go_btn,
    input  logic                 dir,
    output logic [CNT_WIDTH-1:0] led,
    output logic                 done_signal,
    output logic                 busy
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = $clog2(DONE_HOLD + 1);

    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_ONE   = DIV_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TOP   = CNT_WIDTH'(CNT_MAX);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(DONE_HOLD);
    localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Clock-enable divider
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // Go path. The synchroniser carries the inverted button so that the
    // cleared reset value means "not pressed" and no edge follows reset.
    logic go_s1;
    logic go_s2;
    logic pressed_d;
    logic go_pending;
    logic go_edge;
    logic go_req;
    logic abort;

    assign go_edge = go_s2 & ~pressed_d;
    assign go_req  = go_pending | go_edge;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            go_s1      <= 1'b0;
            go_s2      <= 1'b0;
            pressed_d  <= 1'b0;
            go_pending <= 1'b0;
        end else begin
            go_s1     <= ~go_btn;
            go_s2     <= go_s1;
            pressed_d <= go_s2;
            // A tick consumes the request; an edge on the tick cycle is
            // used directly, so it need not be remembered.
            if (tick) begin
                go_pending <= 1'b0;
            end else if (go_edge) begin
                go_pending <= 1'b1;
            end
        end
    end

`ifdef FSM_COUNTER_SEQ_ABORT_EN
    assign abort = go_req;
`else
    assign abort = 1'b0;
`endif

    // Sequencer
    state_t              state;
    state_t              state_n;
    logic [CNT_WIDTH-1:0] led_n;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_n;
    logic                dir_q;
    logic                dir_n;
    logic [CNT_WIDTH-1:0] cnt_end;

    assign cnt_end = dir_q ? '0 : CNT_TOP;

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state    <= S_IDLE;
            led      <= '0;
            hold_cnt <= '0;
            dir_q    <= 1'b0;
        end else begin
            state    <= state_n;
            led      <= led_n;
            hold_cnt <= hold_n;
            dir_q    <= dir_n;
        end
    end

    always_comb begin
        state_n = state;
        led_n   = led;
        hold_n  = hold_cnt;
        dir_n   = dir_q;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    led_n = '0;
                    if (go_req) begin
                        dir_n   = dir;
                        led_n   = dir ? CNT_TOP : '0;
                        state_n = S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (abort) begin
                        state_n = S_IDLE;
                        led_n   = '0;
                    end else if (led == cnt_end) begin
                        state_n = S_DONE;
                        hold_n  = HOLD_ONE;
                    end else if (dir_q) begin
                        led_n = led - CNT_ONE;
                    end else begin
                        led_n = led + CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = S_IDLE;
                        led_n   = '0;
                    end else begin
                        hold_n = hold_cnt + HOLD_ONE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    led_n   = '0;
                end
            endcase
        end
    end

    assign busy        = (state == S_COUNT);
    assign done_signal = (state == S_DONE);

endmodule
